// File: rtl/tdc_tap_decoder.sv
// tdc_tap_decoder: TDC back-end that captures taps, undoes inverter polarity, bubble-corrects,
// encodes first rise/fall positions and block-averages the half-period in taps.
module tdc_tap_decoder #(
    parameter int N_TAPS   = 64,
    parameter int POS_W    = 6,
    parameter int AVG_LOG2 = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [N_TAPS-1:0] taps_in,
    output logic              valid_out,
    output logic [POS_W-1:0]  rise_pos,
    output logic [POS_W-1:0]  fall_pos,
    output logic              rise_ok,
    output logic              fall_ok,
    output logic              no_edge,
    output logic [POS_W:0]    half_per,
    output logic              half_per_valid
);
    localparam int ACC_W = POS_W + AVG_LOG2 + 1;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [N_TAPS-1:0] ALT = {(N_TAPS/2){2'b10}};
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
    state_t            state;
    logic [N_TAPS-1:0] t1, n, b, b2;
    logic              v1, v2, ro, fo, qual;
    logic [POS_W-1:0]  rp, fp, d;
    logic [ACC_W-1:0]  acc, nacc;
    logic [CNT_W-1:0]  cnt, ncnt;
    assign n = t1 ^ ALT;
    always_comb begin
        b = n;
        for (int i = 1; i < N_TAPS - 1; i++)
            b[i] = (n[i-1] & n[i]) | (n[i] & n[i+1]) | (n[i-1] & n[i+1]);
    end
    // descending scan so the lowest matching index is the one kept
    always_comb begin
        rp = '0;
        fp = '0;
        ro = 1'b0;
        fo = 1'b0;
        for (int i = N_TAPS - 1; i >= 1; i--) begin
            if (!b2[i-1] && b2[i]) begin
                rp = POS_W'(i);
                ro = 1'b1;
            end
            if (b2[i-1] && !b2[i]) begin
                fp = POS_W'(i);
                fo = 1'b1;
            end
        end
    end
    assign qual = valid_out & rise_ok & fall_ok;
    assign d    = rise_pos > fall_pos ? rise_pos - fall_pos : fall_pos - rise_pos;
    assign nacc = (state == ACC ? acc : '0) + ACC_W'(d);
    assign ncnt = (state == ACC ? cnt : '0) + CNT_W'(1);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            t1        <= '0;
            v1        <= 1'b0;
            b2        <= '0;
            v2        <= 1'b0;
            valid_out <= 1'b0;
            rise_pos  <= '0;
            fall_pos  <= '0;
            rise_ok   <= 1'b0;
            fall_ok   <= 1'b0;
            no_edge   <= 1'b0;
        end else begin
            v1        <= en;
            v2        <= v1;
            valid_out <= v2;
            if (en) t1 <= taps_in;
            if (v1) b2 <= b;
            if (v2) begin
                rise_pos <= rp;
                fall_pos <= fp;
                rise_ok  <= ro;
                fall_ok  <= fo;
                no_edge  <= !ro && !fo;
            end
        end
    end
    // a sample arriving during DONE sees an empty accumulator and opens the next block
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            acc            <= '0;
            cnt            <= '0;
            half_per       <= '0;
            half_per_valid <= 1'b0;
        end else begin
            half_per_valid <= 1'b0;
            if (qual) begin
                if (ncnt == CNT_W'(1 << AVG_LOG2)) begin
                    state          <= DONE;
                    acc            <= '0;
                    cnt            <= '0;
                    half_per       <= (POS_W+1)'(nacc >> AVG_LOG2);
                    half_per_valid <= 1'b1;
                end else begin
                    state <= ACC;
                    acc   <= nacc;
                    cnt   <= ncnt;
                end
            end else if (state == DONE) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_tdc_tap_decoder.sv
// tb_tdc_tap_decoder: directed scoreboard bench for tdc_tap_decoder.
module tb_tdc_tap_decoder;
    localparam int N = 64;
    localparam logic [N-1:0] ALT = {(N/2){2'b10}};
    typedef struct {
        logic [5:0] rp, fp;
        logic       ro, fo, ne;
        int         cyc;
    } exp_t;
    typedef struct {
        logic [6:0] hp;
        int         cyc;
    } hexp_t;
    logic         clk = 1'b0, rst_n = 1'b0, en = 1'b0;
    logic [N-1:0] taps = '0;
    logic         valid_out, rise_ok, fall_ok, no_edge, half_per_valid;
    logic [5:0]   rise_pos, fall_pos;
    logic [6:0]   half_per;
    int           cyc = 0, n_cmp = 0, n_fail = 0;
    exp_t         q[$];
    hexp_t        hq[$];
    exp_t         e;
    hexp_t        h;
    tdc_tap_decoder dut (
        .clk(clk), .rst_n(rst_n), .en(en), .taps_in(taps), .valid_out(valid_out),
        .rise_pos(rise_pos), .fall_pos(fall_pos), .rise_ok(rise_ok), .fall_ok(fall_ok),
        .no_edge(no_edge), .half_per(half_per), .half_per_valid(half_per_valid)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(string nm, longint act, longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic idle(int k);
        for (int i = 0; i < k; i++) begin
            en = 1'b0;
            taps = {$urandom, $urandom};
            tick();
        end
    endtask
    function automatic logic [N-1:0] band(int lo, int hi);
        logic [N-1:0] v = '0;
        for (int i = lo; i < hi; i++) v[i] = 1'b1;
        return v;
    endfunction
    task automatic chk_zero(string nm);
        check(nm, {valid_out, rise_pos, fall_pos, rise_ok, fall_ok, no_edge, half_per, half_per_valid}, 0);
    endtask
    // hp >= 0 means this sample closes an averaging block with that result
    task automatic send(logic [N-1:0] norm, int rp, int fp, bit ro, bit fo, int hp = -1);
        exp_t  x;
        hexp_t y;
        x.rp = 6'(rp);
        x.fp = 6'(fp);
        x.ro = ro;
        x.fo = fo;
        x.ne = !ro && !fo;
        x.cyc = cyc + 3;
        q.push_back(x);
        if (hp >= 0) begin
            y.hp = 7'(hp);
            y.cyc = cyc + 4;
            hq.push_back(y);
        end
        en = 1'b1;
        taps = norm ^ ALT;
        tick();
        en = 1'b0;
        taps = {$urandom, $urandom};
    endtask
    task automatic both(int r, int f, int hp = -1);
        send(r < f ? band(r, f) : ~band(f, r), r, f, 1'b1, 1'b1, hp);
    endtask
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (valid_out === 1'b1) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_valid: valid_out=1 with no sample pending (cycle %0d)", cyc);
                end else begin
                    e = q.pop_front();
                    check("edges", {rise_pos, fall_pos, rise_ok, fall_ok, no_edge},
                          {e.rp, e.fp, e.ro, e.fo, e.ne});
                    check("valid_latency", cyc, e.cyc);
                end
            end
            if (half_per_valid === 1'b1) begin
                if (hq.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_half_per_valid: half_per=%0d (cycle %0d)", half_per, cyc);
                end else begin
                    h = hq.pop_front();
                    check("half_per", half_per, h.hp);
                    check("half_per_cycle", cyc, h.cyc);
                end
            end
        end
    end
    initial begin
        en = 1'b1;
        taps = band(10, N) ^ ALT;
        tick();
        chk_zero("reset_c1");
        tick();
        chk_zero("reset_c2");
        rst_n = 1'b1;
        en = 1'b0;
        send(band(10, N), 10, 0, 1, 0);
        idle(4);
        send(band(4, N) & ~(N'(1) << 6), 4, 0, 1, 0);
        send(band(4, N) & ~(N'(1) << 5), 5, 0, 1, 0);
        send(band(20, N) | (N'(1) << 8), 20, 0, 1, 0);
        send(N'(1), 0, 1, 0, 1);
        send(N'(1) << 63, 63, 0, 1, 0);
        idle(4);
        for (int i = 0; i < 8; i++) both(10, 30, i == 7 ? 20 : -1);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) send({N{1'b1}}, 0, 0, 0, 0);
            if (i == 4) send('0, 0, 0, 0, 0);
            if (i == 5) send(band(33, N), 33, 0, 1, 0);
            if (i[0]) both(41, 20, i == 7 ? 20 : -1);
            else both(10, 30);
        end
        idle(6);
        for (int i = 0; i < 6; i++) begin
            send(band(10 + i, N), 10 + i, 0, 1, 0);
            idle(1);
        end
        for (int i = 0; i < 4; i++) both(10, 50);
        send(band(0, 2) | (N'(1) << 63), 63, 2, 1, 1);
        idle(5);
        rst_n = 1'b0;
        tick();
        chk_zero("midreset_c1");
        tick();
        chk_zero("midreset_c2");
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) both(10, 17, i == 7 ? 7 : -1);
        idle(3);
        for (int i = 0; i < 16; i++) both(10, 22, (i == 7 || i == 15) ? 12 : -1);
        for (int i = 0; i < 20 && (q.size() != 0 || hq.size() != 0); i++) idle(1);
        idle(2);
        check("pending_samples", q.size(), 0);
        check("pending_half_per", hq.size(), 0);
        check("half_per_hold", half_per, 12);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
